// File: rtl/adder_sequencer.sv
// -----------------------------------------------------------------------------
// adder_sequencer
// Multi-cycle WIDTH-bit adder/subtractor built from one 4-bit carry-lookahead
// slice. After an operand handshake the slice processes one nibble per clock,
// least-significant nibble first. It then presents the result with a
// valid/ready handshake.
//
// Optional feature macro: ADDER_SEQUENCER_SUB_EN
//   defined   : op = 1 selects a - b (b inverted, carry-in forced to 1)
//   undefined : op is ignored, every operation is a + b + c_in
//
// Ports
//   clk        in   1      sole clock, rising edge
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      operand valid
//   in_ready   out  1      operand ready (high only in IDLE)
//   a, b       in   WIDTH  operands
//   c_in       in   1      carry-in for add
//   op         in   1      0 = add, 1 = subtract
//   out_valid  out  1      result valid (high only in DONE)
//   out_ready  in   1      result ready
//   sum        out  WIDTH  result
//   c_out      out  1      final carry (subtract: 1 = no borrow)
//   ovf        out  1      signed overflow
// -----------------------------------------------------------------------------
module adder_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_c_out;
    logic               r_ovf;
    logic [IDX_W-1:0]   r_idx;
    logic               r_last;
    logic [WIDTH-1:0]   w_b_eff;
    logic               w_c_eff;
    logic [3:0]         w_a_nib;
    logic [3:0]         w_b_nib;
    logic [4:0]         w_nib_res;
    logic               w_is_last;

    // 4-bit carry-lookahead slice: returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] x,
                                        input logic [3:0] y,
                                        input logic       ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        logic       co;
        g    = x & y;
        p    = x ^ y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
        return {co, p ^ c};
    endfunction

`ifdef ADDER_SEQUENCER_SUB_EN
    // Subtract is a + ~b + 1, so the operand is inverted before it is latched.
    assign w_b_eff = op ? ~b : b;
    assign w_c_eff = op ? 1'b1 : c_in;
`else
    logic w_unused_op;
    assign w_b_eff     = b;
    assign w_c_eff     = c_in;
    assign w_unused_op = op;
`endif

    assign w_is_last = (r_idx == IDX_W'(N - 1));

    // Select the operand nibbles addressed by the slice index.
    always_comb begin
        w_a_nib = 4'h0;
        w_b_nib = 4'h0;
        for (int k = 0; k < N; k++) begin
            w_a_nib = (r_idx == IDX_W'(k)) ? r_a[4*k +: 4] : w_a_nib;
            w_b_nib = (r_idx == IDX_W'(k)) ? r_b[4*k +: 4] : w_b_nib;
        end
        w_nib_res = cla4(w_a_nib, w_b_nib, r_carry);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic. RUN spends one extra cycle after the last nibble
    // so the final carry and overflow are formed from registered values.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_last) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, per-nibble sum write-back, final flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= w_b_eff;
                        r_carry <= w_c_eff;
                        r_idx   <= '0;
                        r_last  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!r_last) begin
                        for (int k = 0; k < N; k++) begin
                            if (r_idx == IDX_W'(k)) begin
                                r_sum[4*k +: 4] <= w_nib_res[3:0];
                            end
                        end
                        r_carry <= w_nib_res[4];
                        r_idx   <= w_is_last ? '0 : r_idx + IDX_W'(1);
                        r_last  <= w_is_last;
                    end else begin
                        r_c_out <= r_carry;
                        r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1])
                                 & (r_sum[WIDTH-1] != r_a[WIDTH-1]);
                        r_last  <= 1'b0;
                    end
                end
                default: begin
                    r_last <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign c_out     = r_c_out;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_adder_sequencer.sv
module tb_adder_sequencer;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = 16'h0;
    logic [15:0] b = 16'h0;
    logic        c_in = 1'b0;
    logic        op = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        c_out;
    logic        ovf;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];

    adder_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .op(op), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic ci, input logic o);
        exp_t        e;
        logic [15:0] yp;
        logic        cc;
        logic [16:0] r;
        yp = y;
        cc = ci;
`ifdef ADDER_SEQUENCER_SUB_EN
        if (o) begin
            yp = ~y;
            cc = 1'b1;
        end
`endif
        r   = {1'b0, x} + {1'b0, yp} + {16'h0, cc};
        e.s = r[15:0];
        e.c = r[16];
        e.v = (x[15] == yp[15]) && (r[15] != x[15]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge after
    // the accept edge with junk on the operand inputs.
    task automatic start_op(input logic [15:0] x, input logic [15:0] y,
                            input logic ci, input logic o);
        in_valid = 1'b1;
        a = x; b = y; c_in = ci; op = o;
        q.push_back(model(x, y, ci, o));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        c_in = 1'($urandom); op = 1'($urandom);
    endtask

    task automatic wait_result(input string tag, input int hold);
        int   cnt;
        exp_t e;
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_latency"}, cnt, 5);
        e = q.pop_front();
        chk({tag, "_sum"}, sum, e.s);
        chk({tag, "_c_out"}, c_out, e.c);
        chk({tag, "_ovf"}, ovf, e.v);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = 16'($urandom); b = 16'($urandom);
            @(negedge clk);
            chk({tag, "_hold_sum"}, {c_out, ovf, sum}, {e.c, e.v, e.s});
            chk({tag, "_hold_in_ready"}, in_ready, 0);
            chk({tag, "_hold_out_valid"}, out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle_in_ready"}, in_ready, 1);
        chk({tag, "_idle_out_valid"}, out_valid, 0);
        chk({tag, "_idle_sum_held"}, sum, e.s);
    endtask

    initial begin
        logic seen;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outputs", {c_out, ovf, sum}, 0);

        // First accept on the first edge with reset released.
        rst_n = 1'b1;
        start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_result("add_5555", 0);

        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_result("add_carry", 0);

        start_op(16'h7FFF, 16'h0000, 1'b1, 1'b0);
        wait_result("add_ovf", 0);

        start_op(16'h0003, 16'h0002, 1'b0, 1'b1);
        wait_result("op1", 0);

`ifdef ADDER_SEQUENCER_SUB_EN
        start_op(16'h0005, 16'h0007, 1'b1, 1'b1);
        wait_result("sub_borrow", 0);
        start_op(16'h8000, 16'h0001, 1'b0, 1'b1);
        wait_result("sub_ovf", 0);
`endif

        // Result held while out_ready is low; in_valid pulses ignored.
        start_op(16'hA5A5, 16'h1B2C, 1'b1, 1'b0);
        wait_result("hold", 4);

        for (int i = 0; i < 4; i++) begin
            start_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            wait_result("rand", 0);
        end

        // Reset pulse on the edge that would write nibble 2.
        start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        chk("abort_outputs", {c_out, ovf, sum}, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk("abort_no_valid", seen, 0);

        start_op(16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_result("post_abort", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
